mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - N-channel memory bus arbiter; generalises the fixed DMA ID set (USB, SD) to NUM_CH requesters.
// - Multiplexes requester transactions onto one SDRAM-side port (req-held-until-ack protocol).
// - Selectable fixed-priority or round-robin mode, with sticky bursts capped at MAX_BURST grants.
// - Sits between DMA/CPU masters and the SDRAM controller.
// PARAMETERS
// - NUM_CH          2     requester count (>=2); default matches DMA channel count
// - ADDR_W          26    address width
// - DATA_W          16    data width
// - RR_MODE         1     1 = round-robin, 0 = fixed priority (ch0 highest)
// - MAX_BURST       8     max consecutive grants to one channel while others wait (>=1)
// - TIMEOUT_CYCLES  1024  watchdog limit, used only with MEM_BUS_ARB_TIMEOUT_EN
// PORTS
// - clk          in   1                 system clock
// - reset        in   1                 sync, active-high
// - req_i        in   NUM_CH            per-channel request, held until matching ack_o
// - write_i      in   NUM_CH            per-channel 1 = write
// - addr_i       in   NUM_CH*ADDR_W     per-channel address, ch k at [k*ADDR_W +: ADDR_W]
// - wdata_i      in   NUM_CH*DATA_W     per-channel write data
// - ack_o        out  NUM_CH            one-cycle completion pulse to granted channel
// - rdata_o      out  DATA_W            read data, valid with ack_o
// - grant_id_o   out  $clog2(NUM_CH)    currently/last granted channel
// - busy_o       out  1                 transaction in flight
// - error_o      out  1                 one-cycle watchdog abort pulse
// - mem_request  out  1                 downstream request
// - mem_write    out  1                 downstream direction
// - mem_address  out  ADDR_W            downstream address
// - mem_wdata    out  DATA_W            downstream write data
// - mem_ack      in   1                 downstream completion pulse
// - mem_rdata    in   DATA_W            downstream read data, valid with mem_ack
// BEHAVIOUR
// - FSM: IDLE -> XFER. IDLE with any req_i set: latch winner into grant, go XFER next cycle.
// - XFER: mem_request=1. mem_write/address/wdata = registered copy of the winner's fields,
//   latched at grant.
// - In XFER, mem_ack=1: ack_o[grant]=1 and rdata_o=mem_rdata in the same cycle (combinational
//   pass-through); FSM -> IDLE.
// - Minimum 2 cycles between back-to-back grants (one IDLE cycle); requester must drop req_i
//   the cycle after ack_o or be regranted.
// - Arbitration, RR_MODE=1: search starts at grant+1 (wrap mod NUM_CH).
// - Arbitration, RR_MODE=0: lowest index wins.
// - Sticky: if req_i[grant] and burst_cnt<MAX_BURST, regrant same channel; burst_cnt++.
// - Sticky with burst_cnt==MAX_BURST and another req pending: normal arbitration.
// - burst_cnt resets to 1 on grant to a new channel.
// - Sole requester is always regranted; its burst_cnt saturates at MAX_BURST.
// - mem_ack in IDLE is ignored. req_i drop during XFER does not abort; that ack_o is still pulsed.
// - Reset, values next cycle:
//   - FSM IDLE; grant_id_o=0 with RR pointer so ch0 has top priority; burst_cnt=0.
//   - All outputs 0, including mem_request, even mid-XFER; a late mem_ack is ignored.
// - busy_o = (state==XFER).
// CONFIGURATION
// - MEM_BUS_ARB_TIMEOUT_EN defined:
//   - 32-bit cycle counter runs in XFER.
//   - At TIMEOUT_CYCLES without mem_ack: mem_request drops, ack_o[grant] and error_o pulse,
//     rdata_o=0, FSM -> IDLE, burst_cnt=MAX_BURST (forces rotation).
//   - mem_ack arriving in the same cycle as the timeout wins (normal completion, no error).
// - Not defined: error_o tied 0, no counter logic; a hung mem_ack stalls the bus forever.
// TESTING
// - NUM_CH=2, RR: req_i=2'b11 held, mem_ack 3 cycles after each mem_request -> grants alternate
//   0,1,0,1; ack_o one cycle each.
// - RR_MODE=0, req_i=2'b11 held -> ch0 granted MAX_BURST=8 times, then ch1 once, then ch0 again.
// - ch1 read addr 0x123, mem_rdata=0xBEEF with mem_ack -> ack_o=2'b10, rdata_o=0xBEEF same cycle.
// - reset pulsed 2 cycles into XFER -> mem_request=0, busy_o=0 next cycle; following mem_ack
//   gives no ack_o.
// - TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ack never -> error_o and ack_o pulse at cycle 16 of XFER;
//   next waiting channel granted.
// - NUM_CH=4, only ch3 requesting continuously -> ch3 regranted every 2nd cycle, no other ack_o.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: NUM_CH-requester arbiter onto one req-held-until-ack SDRAM port.
// Define MEM_BUS_ARB_TIMEOUT_EN to add the XFER watchdog (abort after TIMEOUT_CYCLES).
module mem_bus_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 16,
  parameter int RR_MODE        = 1,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        write_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     busy_o,
  output logic                     error_o,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_base;
  logic [CNT_W-1:0]  burst_cnt;
  logic [NUM_CH-1:0] others;
  logic [ID_W-1:0]   base;
  logic [ID_W-1:0]   win_lo;
  logic [ID_W-1:0]   win_hi;
  logic              hi_found;
  logic              sticky;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   rr_next;
  logic [CNT_W-1:0]  burst_nxt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout;

  // rr_base is separate from grant so that after reset ch0 is searched first
  always_comb begin
    others         = req_i;
    others[grant]  = 1'b0;
    base           = (RR_MODE != 0) ? rr_base : '0;
    win_lo         = '0;
    win_hi         = '0;
    hi_found       = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      win_lo   = others[j] ? ID_W'(j) : win_lo;
      win_hi   = (others[j] && (ID_W'(j) >= base)) ? ID_W'(j) : win_hi;
      hi_found = (others[j] && (ID_W'(j) >= base)) ? 1'b1 : hi_found;
    end
    sticky = req_i[grant] && ((burst_cnt < CNT_W'(MAX_BURST)) || (others == '0));
    if (sticky) begin
      winner    = grant;
      burst_nxt = (burst_cnt < CNT_W'(MAX_BURST)) ? burst_cnt + CNT_W'(1) : burst_cnt;
    end else begin
      winner    = hi_found ? win_hi : win_lo;
      burst_nxt = CNT_W'(1);
    end
  end

  assign rr_next = (winner == ID_W'(NUM_CH - 1)) ? '0 : winner + ID_W'(1);

  // Pick out the winner's transaction fields for latching at grant
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      sel_write = (winner == ID_W'(j)) ? write_i[j] : sel_write;
      sel_addr  = (winner == ID_W'(j)) ? addr_i[j*ADDR_W +: ADDR_W] : sel_addr;
      sel_wdata = (winner == ID_W'(j)) ? wdata_i[j*DATA_W +: DATA_W] : sel_wdata;
    end
  end

  // Transaction FSM with arbitration state and latched downstream fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_base     <= '0;
      burst_cnt   <= '0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            state       <= XFER;
            grant       <= winner;
            rr_base     <= rr_next;
            burst_cnt   <= burst_nxt;
            mem_write   <= sel_write;
            mem_address <= sel_addr;
            mem_wdata   <= sel_wdata;
          end
        end
        XFER: begin
          if (mem_ack) begin
            state <= IDLE;
          end else if (timeout) begin
            state     <= IDLE;
            burst_cnt <= CNT_W'(MAX_BURST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  logic [31:0] tmr;

  // Cycles spent in the current XFER; a same-cycle mem_ack beats the abort
  always_ff @(posedge clk) begin
    if (reset || (state != XFER)) begin
      tmr <= 32'd0;
    end else begin
      tmr <= tmr + 32'd1;
    end
  end

  assign timeout = (state == XFER) && !mem_ack && (tmr == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Completion is a combinational pass-through of mem_ack so ack_o and rdata_o align with it
  always_comb begin
    ack_o   = '0;
    rdata_o = '0;
    error_o = 1'b0;
    if (!reset && (state == XFER) && (mem_ack || timeout)) begin
      ack_o[grant] = 1'b1;
      rdata_o      = mem_ack ? mem_rdata : '0;
      error_o      = timeout;
    end else begin
      ack_o   = '0;
      rdata_o = '0;
      error_o = 1'b0;
    end
  end

  assign busy_o      = (state == XFER);
  assign mem_request = (state == XFER);
  assign grant_id_o  = grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a 2-ch fixed-priority instance and a 4-ch round-robin one.
module tb_mem_bus_arbiter;
  localparam int AW = 26;
  localparam int DW = 16;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            len;
    int            gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  int            target  [2][4];
  int            acked   [2][4];
  logic [AW-1:0] ch_addr [2][4];
  logic          ch_wr   [2][4];
  logic [DW-1:0] ch_wd   [2][4];
  logic          rsp_en    [2];
  int            rsp_lat   [2];
  logic [DW-1:0] rsp_base  [2];
  logic          rsp_force [2];

  logic [1:0][3:0]    req;
  logic [1:0][3:0]    ack;
  logic [1:0][1:0]    gid;
  logic [1:0][DW-1:0] rdata;
  logic [1:0]         busy;
  logic [1:0]         err;
  logic [1:0]         mreq;
  logic [1:0]         mwr;
  logic [1:0][AW-1:0] maddr;
  logic [1:0][DW-1:0] mwd;
  logic [1:0]         mack;
  logic [1:0][DW-1:0] mrd;

  // Requesters hold req until they have seen as many acks as they were asked for
  always_comb begin
    req = '0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        req[d][c] = (acked[d][c] < target[d][c]);
  end

  assign ack[0][3:2] = 2'b00;
  assign gid[0][1]   = 1'b0;

  mem_bus_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_BURST(8),
                    .TIMEOUT_CYCLES(16)) u_fp (
    .clk(clk), .reset(reset), .req_i(req[0][1:0]),
    .write_i({ch_wr[0][1], ch_wr[0][0]}), .addr_i({ch_addr[0][1], ch_addr[0][0]}),
    .wdata_i({ch_wd[0][1], ch_wd[0][0]}), .ack_o(ack[0][1:0]), .rdata_o(rdata[0]),
    .grant_id_o(gid[0][0:0]), .busy_o(busy[0]), .error_o(err[0]), .mem_request(mreq[0]),
    .mem_write(mwr[0]), .mem_address(maddr[0]), .mem_wdata(mwd[0]), .mem_ack(mack[0]),
    .mem_rdata(mrd[0]));

  mem_bus_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_BURST(1),
                    .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .reset(reset), .req_i(req[1]),
    .write_i({ch_wr[1][3], ch_wr[1][2], ch_wr[1][1], ch_wr[1][0]}),
    .addr_i({ch_addr[1][3], ch_addr[1][2], ch_addr[1][1], ch_addr[1][0]}),
    .wdata_i({ch_wd[1][3], ch_wd[1][2], ch_wd[1][1], ch_wd[1][0]}),
    .ack_o(ack[1]), .rdata_o(rdata[1]), .grant_id_o(gid[1]), .busy_o(busy[1]),
    .error_o(err[1]), .mem_request(mreq[1]), .mem_write(mwr[1]), .mem_address(maddr[1]),
    .mem_wdata(mwd[1]), .mem_ack(mack[1]), .mem_rdata(mrd[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int ch, input logic [DW-1:0] rd, input logic er,
                      input int len, input int gap);
    exp_t e;
    e.ch = ch; e.addr = ch_addr[d][ch]; e.wr = ch_wr[d][ch]; e.wdata = ch_wd[d][ch];
    e.rdata = rd; e.err = er; e.len = len; e.gap = gap;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic logic [DW-1:0] exp_rd(input int d, input int ch);
    return rsp_base[d] ^ ch_addr[d][ch][DW-1:0];
  endfunction

  task automatic wait_empty(input int d, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (((d == 0) ? q0.size() : q1.size()) == 0) break;
      @(posedge clk);
    end
    check(name, (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  // Memory model: acks rsp_lat cycles after mem_request rises, data = rsp_base ^ address
  initial begin : responder
    int cnt [2];
    for (int d = 0; d < 2; d++) begin cnt[d] = 0; mack[d] = 1'b0; mrd[d] = '0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        mack[d] = 1'b0;
        if (rsp_force[d]) begin
          mack[d] = 1'b1;
        end else if (rsp_en[d] && mreq[d]) begin
          if (cnt[d] == rsp_lat[d]) begin
            mack[d] = 1'b1;
            mrd[d]  = rsp_base[d] ^ maddr[d][DW-1:0];
            cnt[d]  = 0;
          end else begin
            cnt[d]++;
          end
        end else begin
          cnt[d] = 0;
        end
      end
    end
  end

  // Monitor: every ack pops the scoreboard and compares all transaction fields
  initial begin : monitor
    int xlen [2];
    int last [2];
    int cyc;
    exp_t e;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin xlen[d] = 0; last[d] = 0; end
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        xlen[d] = busy[d] ? xlen[d] + 1 : 0;
        if (ack[d] != 4'b0000) begin
          for (int c = 0; c < 4; c++) if (ack[d][c]) acked[d][c]++;
          if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            check($sformatf("d%0d_unexpected_ack", d), ack[d], 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("d%0d_ack_vec", d), ack[d], 4'b0001 << e.ch);
            check($sformatf("d%0d_grant_id", d), gid[d], e.ch);
            check($sformatf("d%0d_mem_address", d), maddr[d], e.addr);
            check($sformatf("d%0d_mem_write", d), mwr[d], e.wr);
            if (e.wr) check($sformatf("d%0d_mem_wdata", d), mwd[d], e.wdata);
            check($sformatf("d%0d_rdata", d), rdata[d], e.rdata);
            check($sformatf("d%0d_error", d), err[d], e.err);
            if (e.len != 0) check($sformatf("d%0d_xfer_len", d), xlen[d], e.len);
            if (e.gap != 0) check($sformatf("d%0d_ack_gap", d), cyc - last[d], e.gap);
          end
          last[d] = cyc;
        end else if (err[d]) begin
          check($sformatf("d%0d_spurious_error", d), err[d], 0);
        end
      end
    end
  end

  initial begin : stimulus
    for (int d = 0; d < 2; d++) begin
      rsp_en[d] = 1'b1; rsp_lat[d] = 0; rsp_base[d] = '0; rsp_force[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        target[d][c] = 0; acked[d][c] = 0;
        ch_addr[d][c] = '0; ch_wr[d][c] = 1'b0; ch_wd[d][c] = '0;
      end
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_reset_ctrl", d), {ack[d], gid[d], busy[d], mreq[d], err[d], mwr[d]}, 0);
      check($sformatf("d%0d_reset_data", d), {rdata[d], maddr[d], mwd[d]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Fixed priority: ch0 (write) bursts 8 times, ch1 once, ch0 again
    @(posedge clk); #1;
    ch_addr[0][0] = 26'h0000100; ch_wr[0][0] = 1'b1; ch_wd[0][0] = 16'h1111;
    ch_addr[0][1] = 26'h0000200; ch_wr[0][1] = 1'b0;
    rsp_lat[0] = 1; rsp_base[0] = 16'h3C3C;
    for (int i = 0; i < 8; i++) push(0, 0, exp_rd(0, 0), 1'b0, 2, (i == 0) ? 0 : 3);
    push(0, 1, exp_rd(0, 1), 1'b0, 2, 3);
    push(0, 0, exp_rd(0, 0), 1'b0, 2, 3);
    target[0][0] = 9; target[0][1] = 1;
    wait_empty(0, 300, "fp_burst_done");

    // ch1 read of 0x123 returns 0xBEEF in the ack cycle
    @(posedge clk); #1;
    ch_addr[0][1] = 26'h0000123;
    rsp_base[0] = 16'hBFCC;
    push(0, 1, 16'hBEEF, 1'b0, 2, 0);
    target[0][1] = acked[0][1] + 1;
    wait_empty(0, 50, "beef_read_done");

    // Round robin, MAX_BURST=1, ch0+ch1 held, 3-cycle memory latency -> 0,1,0,1
    @(posedge clk); #1;
    ch_addr[1][0] = 26'h0000040; ch_addr[1][1] = 26'h0000080;
    rsp_lat[1] = 3; rsp_base[1] = 16'h1234;
    push(1, 0, exp_rd(1, 0), 1'b0, 4, 0);
    push(1, 1, exp_rd(1, 1), 1'b0, 4, 5);
    push(1, 0, exp_rd(1, 0), 1'b0, 4, 5);
    push(1, 1, exp_rd(1, 1), 1'b0, 4, 5);
    target[1][0] = 2; target[1][1] = 2;
    wait_empty(1, 200, "rr_alt_done");

    // Sole requester ch3 at the top address, zero-latency memory -> ack every 2nd cycle
    @(posedge clk); #1;
    ch_addr[1][3] = 26'h3FFFFFF; ch_wr[1][3] = 1'b1; ch_wd[1][3] = 16'hA5A5;
    rsp_lat[1] = 0;
    for (int i = 0; i < 4; i++) push(1, 3, exp_rd(1, 3), 1'b0, 1, (i == 0) ? 0 : 2);
    target[1][3] = 4;
    wait_empty(1, 100, "sole_ch3_done");

    // Reset two cycles into an XFER; a late mem_ack must not produce ack_o
    @(posedge clk); #1;
    rsp_en[1] = 1'b0;
    ch_addr[1][2] = 26'h0000055;
    target[1][2] = acked[1][2] + 1;
    for (int i = 0; i < 20; i++) begin
      if (mreq[1]) break;
      @(posedge clk); #1;
    end
    check("rst_xfer_started", mreq[1], 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    target[1][2] = acked[1][2];
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
    check("rst_mid_xfer_state", {mreq[1], busy[1], gid[1], ack[1], err[1]}, 0);
    @(posedge clk); #1;
    rsp_force[1] = 1'b1;
    @(negedge clk); #2;
    check("late_mem_ack_ignored", ack[1], 0);
    @(posedge clk); #1;
    rsp_force[1] = 1'b0;
    rsp_en[1] = 1'b1;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // Hung memory: each grant aborts at XFER cycle 16 and rotation moves to the waiting channel
    @(posedge clk); #1;
    rsp_en[1] = 1'b0;
    ch_addr[1][1] = 26'h00002AA; ch_addr[1][2] = 26'h0000155;
    push(1, 1, 16'h0000, 1'b1, 16, 0);
    push(1, 2, 16'h0000, 1'b1, 16, 17);
    push(1, 1, 16'h0000, 1'b1, 16, 17);
    target[1][1] = acked[1][1] + 2; target[1][2] = acked[1][2] + 1;
    wait_empty(1, 200, "timeout_done");
    @(posedge clk); #1;
    rsp_en[1] = 1'b1;
`endif

    repeat (5) @(posedge clk);
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
